pang_issue_seq: RTL

Sequencer that drives the per-pang sub-block extraction pipeline (`next_sft`, `zNeedFull`, `zNeedPangStartInc`, `zNeedPangEndInc`). It accepts variable-length requests of 1–16 sub-blocks and issues one selection command per cycle from a wrapping sub-block pointer. It pops the upstream pang word when the pointer wraps, and tracks the 5-cycle pipeline so it can flag when each extracted sub-block is valid and when a request has fully drained.

---
 rtl/pang_issue_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pang_issue_seq.sv
// pang_issue_seq: sequencer for the per-pang sub-block extraction pipeline.
// Accepts requests of 1..16 sub-blocks and issues one selection command per
// cycle from a wrapping sub-block pointer. It pops the pang word when the
// pointer passes sub-block 15. It tracks in-flight commands so that it can
// flag output validity and request completion.
// Optional feature: define PANG_SEQ_STALL_CNT_EN to add the stall_cnt port,
// a saturating count of ISSUE cycles that were stalled on pang_valid.
// PIPE_DEPTH must be at least 2.
module pang_issue_seq #(
  parameter int PIPE_DEPTH = 5,
  parameter int SFT_BIT    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [SFT_BIT:0]   req_len,
  output logic               req_ready,
  input  logic               pang_valid,
  output logic               pang_pop,
  output logic [SFT_BIT-1:0] next_sft,
  output logic               need_full,
  output logic [SFT_BIT-1:0] start_inc,
  output logic [SFT_BIT-1:0] end_inc,
  output logic               cmd_valid,
  output logic               out_valid,
  output logic               req_done
`ifdef PANG_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [SFT_BIT-1:0] SFT_ONE  = {{(SFT_BIT-1){1'b0}}, 1'b1};
  localparam logic [SFT_BIT-1:0] SFT_LAST = {SFT_BIT{1'b1}};
  localparam logic [SFT_BIT:0]   REM_ONE  = {{SFT_BIT{1'b0}}, 1'b1};
  localparam logic [SFT_BIT:0]   REM_ZERO = {(SFT_BIT+1){1'b0}};

  state_t                state_r;
  logic [SFT_BIT-1:0]    ptr_r;
  logic [SFT_BIT:0]      remain_r;
  logic [SFT_BIT-1:0]    start_r;
  logic [SFT_BIT-1:0]    end_r;
  logic [SFT_BIT-1:0]    last_sft_r;
  logic [PIPE_DEPTH-1:0] pipe_r;

  logic issue_s;
  logic done_s;

  // A command goes out on every ISSUE cycle that has a loaded pang word.
  assign issue_s = (state_r == ISSUE) && pang_valid;

  // The request is finished once the only in-flight command left is in the
  // final pipeline stage; that stage's out_valid coincides with req_done.
  assign done_s  = (state_r == DRAIN) &&
                   (pipe_r[PIPE_DEPTH-2:0] == {(PIPE_DEPTH-1){1'b0}});

  // req_ready is forced low while reset is held so that every output is 0.
  assign req_ready = (state_r == IDLE) && !reset;
  assign cmd_valid = issue_s;
  assign need_full = issue_s;
  assign next_sft  = issue_s ? ptr_r : last_sft_r;
  assign pang_pop  = issue_s && (ptr_r == SFT_LAST);
  assign start_inc = start_r;
  assign end_inc   = end_r;
  assign out_valid = pipe_r[PIPE_DEPTH-1];
  assign req_done  = done_s;

  // Sequencer FSM: request acceptance, per-cycle issue with pointer wrap, drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= {SFT_BIT{1'b0}};
      remain_r   <= REM_ZERO;
      start_r    <= {SFT_BIT{1'b0}};
      end_r      <= {SFT_BIT{1'b0}};
      last_sft_r <= {SFT_BIT{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // A zero-length request is illegal and is simply ignored.
          if (req_valid && (req_len != REM_ZERO)) begin
            start_r  <= ptr_r;
            // A length of 16 truncates to 0, which gives ptr-1 (mod 16).
            end_r    <= ptr_r + req_len[SFT_BIT-1:0] - SFT_ONE;
            remain_r <= req_len;
            state_r  <= ISSUE;
          end else begin
            state_r  <= IDLE;
          end
        end
        ISSUE: begin
          if (pang_valid) begin
            last_sft_r <= ptr_r;
            ptr_r      <= ptr_r + SFT_ONE;
            remain_r   <= remain_r - REM_ONE;
            if (remain_r == REM_ONE) begin
              state_r <= DRAIN;
            end else begin
              state_r <= ISSUE;
            end
          end else begin
            state_r <= ISSUE;
          end
        end
        DRAIN: begin
          if (done_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Issue-tracking shift register; its last stage is out_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_r <= {PIPE_DEPTH{1'b0}};
    end else begin
      pipe_r <= {pipe_r[PIPE_DEPTH-2:0], issue_s};
    end
  end

`ifdef PANG_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  assign stall_cnt = stall_cnt_r;

  // Saturating count of ISSUE cycles stalled waiting for a pang word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
    end else if ((state_r == ISSUE) && !pang_valid && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule
